// File: rtl/max_tracker_pipe.sv
// -----------------------------------------------------------------------------
// max_tracker_pipe
//
// Tracks the maximum score, and the row/column where it occurred, across a
// frame of multi-lane beats. Each accepted beat is reduced to a single winner
// by a registered binary comparator tree (one register level per tree level).
// The winner then folds into a running accumulator, and the accumulator is
// copied into the registered max_* outputs.
//
// Latency: a beat accepted at edge k is visible on max_* after edge k+L+1,
// where L = log2(NUM_LANES):
//    edges k .. k+L-1 : tree levels 1..L
//    edge  k+L        : accumulator
//    edge  k+L+1      : output register
//
// Ports
//    clk           : single clock, rising edge
//    rst_n         : synchronous active-low reset (has priority over start)
//    start         : begin a new frame; aborts any frame in progress
//    in_valid      : qualifies a beat
//    in_last       : marks the final beat of a frame
//    lane_en       : per-lane enable; a disabled lane never wins
//    score_in      : NUM_LANES unsigned scores, lane i at [i*SCORE_WIDTH +: SCORE_WIDTH]
//    row_in        : NUM_LANES row indices, packed the same way
//    col_in        : NUM_LANES column indices, packed the same way
//    max_score     : running maximum score of the current/last frame
//    max_row       : row of the running maximum
//    max_col       : column of the running maximum
//    busy          : high while a frame is ACTIVE or DRAINing
//    done          : one-cycle pulse when the final beat has folded in
//    result_valid  : high while max_* hold a completed frame result
// -----------------------------------------------------------------------------
module max_tracker_pipe #(
   parameter int NUM_LANES      = 16,
   parameter int SCORE_WIDTH    = 8,
   parameter int ROW_BITS_WIDTH = 7,
   parameter int COL_BITS_WIDTH = 7
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                in_valid,
   input  logic                                in_last,
   input  logic [NUM_LANES-1:0]                lane_en,
   input  logic [NUM_LANES*SCORE_WIDTH-1:0]    score_in,
   input  logic [NUM_LANES*ROW_BITS_WIDTH-1:0] row_in,
   input  logic [NUM_LANES*COL_BITS_WIDTH-1:0] col_in,
   output logic [SCORE_WIDTH-1:0]              max_score,
   output logic [ROW_BITS_WIDTH-1:0]           max_row,
   output logic [COL_BITS_WIDTH-1:0]           max_col,
   output logic                                busy,
   output logic                                done,
   output logic                                result_valid
);

   localparam int LVL = $clog2(NUM_LANES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                    state_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      result_valid_q;
   logic [SCORE_WIDTH-1:0]    max_score_q;
   logic [ROW_BITS_WIDTH-1:0] max_row_q;
   logic [COL_BITS_WIDTH-1:0] max_col_q;

   logic                      accept_s;

   logic                      lane_en_s    [NUM_LANES];
   logic [SCORE_WIDTH-1:0]    lane_score_s [NUM_LANES];
   logic [ROW_BITS_WIDTH-1:0] lane_row_s   [NUM_LANES];
   logic [COL_BITS_WIDTH-1:0] lane_col_s   [NUM_LANES];

   logic                      top_vld_s;
   logic                      top_lst_s;
   logic                      top_en_s;
   logic [SCORE_WIDTH-1:0]    top_score_s;
   logic [ROW_BITS_WIDTH-1:0] top_row_s;
   logic [COL_BITS_WIDTH-1:0] top_col_s;

   logic                      take_s;
   logic [SCORE_WIDTH-1:0]    acc_score_d, acc_score_q;
   logic [ROW_BITS_WIDTH-1:0] acc_row_d,   acc_row_q;
   logic [COL_BITS_WIDTH-1:0] acc_col_d,   acc_col_q;
   logic                      fold_last_d, fold_last_q;

   // Beat acceptance: a beat is taken in ACTIVE, or together with start from
   // any state (it then becomes the first beat of the new frame).
   always_comb begin
      accept_s = in_valid & (start | (state_q == ST_ACTIVE));
   end

   // Unpack the flat lane buses into per-lane arrays.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_en_s[i]    = lane_en[i];
         lane_score_s[i] = score_in[i*SCORE_WIDTH +: SCORE_WIDTH];
         lane_row_s[i]   = row_in[i*ROW_BITS_WIDTH +: ROW_BITS_WIDTH];
         lane_col_s[i]   = col_in[i*COL_BITS_WIDTH +: COL_BITS_WIDTH];
      end
   end

   // -------------------------------------------------------------------------
   // Comparator tree. Level l halves the node count of level l-1. Each node
   // carries an enable (at least one enabled lane below it) plus the winning
   // score/row/col; each level carries its own valid and last flags.
   // -------------------------------------------------------------------------
   for (genvar l = 1; l <= LVL; l++) begin : g_lvl
      localparam int N = NUM_LANES >> l;

      logic                      src_en_s    [2*N];
      logic [SCORE_WIDTH-1:0]    src_score_s [2*N];
      logic [ROW_BITS_WIDTH-1:0] src_row_s   [2*N];
      logic [COL_BITS_WIDTH-1:0] src_col_s   [2*N];
      logic                      src_vld_s;
      logic                      src_lst_s;

      logic                      en_d    [N];
      logic [SCORE_WIDTH-1:0]    score_d [N];
      logic [ROW_BITS_WIDTH-1:0] row_d   [N];
      logic [COL_BITS_WIDTH-1:0] col_d   [N];
      logic                      vld_d;
      logic                      lst_d;

      logic                      en_q    [N];
      logic [SCORE_WIDTH-1:0]    score_q [N];
      logic [ROW_BITS_WIDTH-1:0] row_q   [N];
      logic [COL_BITS_WIDTH-1:0] col_q   [N];
      logic                      vld_q;
      logic                      lst_q;

      if (l == 1) begin : g_src
         // First level reads the lanes; a beat taken with start belongs to
         // the new frame, so start does not squash it here.
         always_comb begin
            for (int j = 0; j < 2*N; j++) begin
               src_en_s[j]    = lane_en_s[j];
               src_score_s[j] = lane_score_s[j];
               src_row_s[j]   = lane_row_s[j];
               src_col_s[j]   = lane_col_s[j];
            end
            src_vld_s = accept_s;
            src_lst_s = in_last;
         end
      end else begin : g_src
         // Deeper levels read the previous level; start discards in-flight beats.
         always_comb begin
            for (int j = 0; j < 2*N; j++) begin
               src_en_s[j]    = g_lvl[l-1].en_q[j];
               src_score_s[j] = g_lvl[l-1].score_q[j];
               src_row_s[j]   = g_lvl[l-1].row_q[j];
               src_col_s[j]   = g_lvl[l-1].col_q[j];
            end
            src_vld_s = g_lvl[l-1].vld_q & ~start;
            src_lst_s = g_lvl[l-1].lst_q;
         end
      end

      // Pairwise compare: the lower index wins ties, a disabled side never wins.
      always_comb begin
         for (int j = 0; j < N; j++) begin
            if (src_en_s[2*j] &&
                (!src_en_s[2*j+1] || (src_score_s[2*j] >= src_score_s[2*j+1]))) begin
               score_d[j] = src_score_s[2*j];
               row_d[j]   = src_row_s[2*j];
               col_d[j]   = src_col_s[2*j];
            end else begin
               score_d[j] = src_score_s[2*j+1];
               row_d[j]   = src_row_s[2*j+1];
               col_d[j]   = src_col_s[2*j+1];
            end
            en_d[j] = src_en_s[2*j] | src_en_s[2*j+1];
         end
         vld_d = src_vld_s;
         lst_d = src_lst_s;
      end

      // Level pipeline register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            lst_q <= 1'b0;
            for (int j = 0; j < N; j++) begin
               en_q[j]    <= 1'b0;
               score_q[j] <= {SCORE_WIDTH{1'b0}};
               row_q[j]   <= {ROW_BITS_WIDTH{1'b0}};
               col_q[j]   <= {COL_BITS_WIDTH{1'b0}};
            end
         end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
            for (int j = 0; j < N; j++) begin
               en_q[j]    <= en_d[j];
               score_q[j] <= score_d[j];
               row_q[j]   <= row_d[j];
               col_q[j]   <= col_d[j];
            end
         end
      end
   end

   // Tree root: the single surviving node of the last level.
   always_comb begin
      top_vld_s   = g_lvl[LVL].vld_q;
      top_lst_s   = g_lvl[LVL].lst_q;
      top_en_s    = g_lvl[LVL].en_q[0];
      top_score_s = g_lvl[LVL].score_q[0];
      top_row_s   = g_lvl[LVL].row_q[0];
      top_col_s   = g_lvl[LVL].col_q[0];
   end

   // Accumulator next state: replace only on a strictly greater score so the
   // earlier beat keeps a tie; an all-disabled beat changes nothing.
   always_comb begin
      take_s = top_vld_s & top_en_s & (top_score_s > acc_score_q);
      if (start) begin
         acc_score_d = {SCORE_WIDTH{1'b0}};
         acc_row_d   = {ROW_BITS_WIDTH{1'b0}};
         acc_col_d   = {COL_BITS_WIDTH{1'b0}};
         fold_last_d = 1'b0;
      end else if (take_s) begin
         acc_score_d = top_score_s;
         acc_row_d   = top_row_s;
         acc_col_d   = top_col_s;
         fold_last_d = top_vld_s & top_lst_s;
      end else begin
         acc_score_d = acc_score_q;
         acc_row_d   = acc_row_q;
         acc_col_d   = acc_col_q;
         fold_last_d = top_vld_s & top_lst_s;
      end
   end

   // Accumulator register; fold_last_q flags that the final beat just folded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_score_q <= {SCORE_WIDTH{1'b0}};
         acc_row_q   <= {ROW_BITS_WIDTH{1'b0}};
         acc_col_q   <= {COL_BITS_WIDTH{1'b0}};
         fold_last_q <= 1'b0;
      end else begin
         acc_score_q <= acc_score_d;
         acc_row_q   <= acc_row_d;
         acc_col_q   <= acc_col_d;
         fold_last_q <= fold_last_d;
      end
   end

   // Control FSM with registered status and max_* outputs. The outputs follow
   // the accumulator one edge later, which lines done up with the final value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         max_score_q    <= {SCORE_WIDTH{1'b0}};
         max_row_q      <= {ROW_BITS_WIDTH{1'b0}};
         max_col_q      <= {COL_BITS_WIDTH{1'b0}};
      end else if (start) begin
         // New frame (or abort): a single-beat frame goes straight to DRAIN.
         state_q        <= (accept_s && in_last) ? ST_DRAIN : ST_ACTIVE;
         busy_q         <= 1'b1;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         max_score_q    <= {SCORE_WIDTH{1'b0}};
         max_row_q      <= {ROW_BITS_WIDTH{1'b0}};
         max_col_q      <= {COL_BITS_WIDTH{1'b0}};
      end else begin
         max_score_q <= acc_score_q;
         max_row_q   <= acc_row_q;
         max_col_q   <= acc_col_q;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               busy_q <= 1'b0;
            end
            ST_ACTIVE: begin
               if (accept_s && in_last) begin
                  state_q <= ST_DRAIN;
               end else begin
                  state_q <= ST_ACTIVE;
               end
            end
            ST_DRAIN: begin
               if (fold_last_q) begin
                  state_q        <= ST_IDLE;
                  busy_q         <= 1'b0;
                  done_q         <= 1'b1;
                  result_valid_q <= 1'b1;
               end else begin
                  state_q <= ST_DRAIN;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign max_score    = max_score_q;
   assign max_row      = max_row_q;
   assign max_col      = max_col_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_max_tracker_pipe.sv
// -----------------------------------------------------------------------------
// tb_max_tracker_pipe
//
// Directed and randomized stimulus for max_tracker_pipe with 4 lanes (L = 2).
// A behavioural model keeps a queue of accepted beats, each tagged with the
// edge at which its winner must appear on max_*, and folds them into a frame
// maximum. Every output is compared against the model after every edge.
// -----------------------------------------------------------------------------
module tb_max_tracker_pipe;

   localparam int NL = 4;
   localparam int SW = 8;
   localparam int RW = 7;
   localparam int CW = 7;
   localparam int L  = 2;

   localparam int S_IDLE   = 0;
   localparam int S_ACTIVE = 1;
   localparam int S_DRAIN  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic              in_last;
   logic [NL-1:0]     lane_en;
   logic [NL*SW-1:0]  score_in;
   logic [NL*RW-1:0]  row_in;
   logic [NL*CW-1:0]  col_in;
   logic [SW-1:0]     max_score;
   logic [RW-1:0]     max_row;
   logic [CW-1:0]     max_col;
   logic              busy;
   logic              done;
   logic              result_valid;

   always #5 clk = ~clk;

   max_tracker_pipe #(
      .NUM_LANES      (NL),
      .SCORE_WIDTH    (SW),
      .ROW_BITS_WIDTH (RW),
      .COL_BITS_WIDTH (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .lane_en      (lane_en),
      .score_in     (score_in),
      .row_in       (row_in),
      .col_in       (col_in),
      .max_score    (max_score),
      .max_row      (max_row),
      .max_col      (max_col),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid)
   );

   typedef struct {
      int due;
      bit win;
      int sc;
      int row;
      int col;
      bit last;
   } beat_t;

   beat_t q[$];
   int    checks = 0;
   int    errors = 0;
   int    edge_n = 0;
   int    m_state = S_IDLE;
   int    m_sc = 0;
   int    m_row = 0;
   int    m_col = 0;
   bit    m_done = 1'b0;
   bit    m_rv = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Record the beat on the inputs: best enabled lane, lowest index on ties.
   task automatic push_beat();
      beat_t b;
      int    best;
      best = -1;
      for (int i = 0; i < NL; i++) begin
         if (lane_en[i] && (best < 0 || int'(score_in[i*SW +: SW]) > int'(score_in[best*SW +: SW])))
            best = i;
      end
      b.due  = edge_n + L + 1;
      b.win  = (best >= 0);
      b.sc   = (best >= 0) ? int'(score_in[best*SW +: SW]) : 0;
      b.row  = (best >= 0) ? int'(row_in[best*RW +: RW]) : 0;
      b.col  = (best >= 0) ? int'(col_in[best*CW +: CW]) : 0;
      b.last = in_last;
      q.push_back(b);
   endtask

   // Advance the model by one rising edge using the inputs driven for it.
   task automatic model_edge();
      beat_t b;
      edge_n++;
      if (!rst_n) begin
         q.delete();
         m_state = S_IDLE;
         m_sc = 0; m_row = 0; m_col = 0;
         m_done = 1'b0; m_rv = 1'b0;
      end else if (start) begin
         q.delete();
         m_sc = 0; m_row = 0; m_col = 0;
         m_done = 1'b0; m_rv = 1'b0;
         if (in_valid) push_beat();
         m_state = (in_valid && in_last) ? S_DRAIN : S_ACTIVE;
      end else begin
         m_done = 1'b0;
         if (m_state == S_ACTIVE && in_valid) begin
            push_beat();
            if (in_last) m_state = S_DRAIN;
         end
         while (q.size() > 0 && q[0].due == edge_n) begin
            b = q.pop_front();
            if (b.win && b.sc > m_sc) begin
               m_sc = b.sc; m_row = b.row; m_col = b.col;
            end
            if (b.last) begin
               m_done = 1'b1;
               m_rv = 1'b1;
               m_state = S_IDLE;
            end
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check({tag, ".score"}, 32'(max_score), 32'(m_sc));
      check({tag, ".row"},   32'(max_row),   32'(m_row));
      check({tag, ".col"},   32'(max_col),   32'(m_col));
      check({tag, ".busy"},  32'(busy),      32'(m_state != S_IDLE));
      check({tag, ".done"},  32'(done),      32'(m_done));
      check({tag, ".rv"},    32'(result_valid), 32'(m_rv));
   endtask

   task automatic beat(input string tag, input logic s, input logic v, input logic lst,
                       input logic [NL-1:0] en, input logic [NL*SW-1:0] sc,
                       input logic [NL*RW-1:0] rw, input logic [NL*CW-1:0] cl);
      start = s; in_valid = v; in_last = lst;
      lane_en = en; score_in = sc; row_in = rw; col_in = cl;
      tick(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
         tick(tag);
      end
   endtask

   task automatic rand_lanes();
      lane_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      for (int i = 0; i < NL; i++) begin
         score_in[i*SW +: SW] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                                            : 8'($urandom_range(0, 255));
         row_in[i*RW +: RW] = 7'($urandom_range(0, 127));
         col_in[i*CW +: CW] = 7'($urandom_range(0, 127));
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      lane_en = 4'b0000; score_in = 32'd0; row_in = 28'd0; col_in = 28'd0;

      // Reset state
      tick("rst0");
      tick("rst1");
      check("rst.score", 32'(max_score), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      // in_valid in IDLE without start is ignored
      beat("idle_ign", 1'b0, 1'b1, 1'b1, 4'b1111, {8'd9, 8'd9, 8'd9, 8'd9}, 28'd0, 28'd0);
      idle("idle_ign", 3);
      check("idle_ign.busy", 32'(busy), 32'd0);

      // Single-beat frame
      beat("t1", 1'b1, 1'b1, 1'b1, 4'b1111, {8'd5, 8'd20, 8'd50, 8'd10},
           {7'd4, 7'd3, 7'd2, 7'd1}, {7'd3, 7'd2, 7'd1, 7'd0});
      idle("t1", 2);
      check("t1.pre_done", 32'(done), 32'd0);
      idle("t1", 1);
      check("t1.max", 32'(max_score), 32'd50);
      check("t1.row", 32'(max_row), 32'd2);
      check("t1.col", 32'(max_col), 32'd1);
      check("t1.done", 32'(done), 32'd1);
      check("t1.rv", 32'(result_valid), 32'd1);
      idle("t1", 2);
      check("t1.done_pulse", 32'(done), 32'd0);
      check("t1.rv_hold", 32'(result_valid), 32'd1);
      check("t1.max_hold", 32'(max_score), 32'd50);

      // Three beats: 30, then 90 (in-tree tie lane1 vs lane2), then 90 at row 7
      beat("t2", 1'b1, 1'b1, 1'b0, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd30},
           {7'd1, 7'd1, 7'd1, 7'd1}, {7'd0, 7'd0, 7'd0, 7'd0});
      check("t2.rv_drop", 32'(result_valid), 32'd0);
      beat("t2", 1'b0, 1'b1, 1'b0, 4'b1111, {8'd5, 8'd90, 8'd90, 8'd0},
           {7'd2, 7'd6, 7'd5, 7'd2}, {7'd2, 7'd11, 7'd9, 7'd2});
      beat("t2", 1'b0, 1'b1, 1'b1, 4'b1111, {8'd8, 8'd7, 8'd6, 8'd90},
           {7'd7, 7'd7, 7'd7, 7'd7}, {7'd4, 7'd4, 7'd4, 7'd4});
      idle("t2", 3);
      check("t2.max", 32'(max_score), 32'd90);
      check("t2.row", 32'(max_row), 32'd5);
      check("t2.col", 32'(max_col), 32'd9);
      check("t2.done", 32'(done), 32'd1);

      // Lane masking
      beat("t3", 1'b1, 1'b1, 1'b1, 4'b1110, {8'd5, 8'd4, 8'd3, 8'd200},
           {7'd13, 7'd12, 7'd11, 7'd10}, {7'd23, 7'd22, 7'd21, 7'd20});
      idle("t3", 3);
      check("t3.max", 32'(max_score), 32'd5);
      check("t3.row", 32'(max_row), 32'd13);

      // All-masked beat, then a last beat of all zeros
      beat("t4", 1'b1, 1'b1, 1'b0, 4'b0000, {8'd99, 8'd99, 8'd99, 8'd99},
           {7'd9, 7'd9, 7'd9, 7'd9}, {7'd9, 7'd9, 7'd9, 7'd9});
      beat("t4", 1'b0, 1'b1, 1'b1, 4'b1111, {8'd0, 8'd0, 8'd0, 8'd0},
           {7'd3, 7'd2, 7'd1, 7'd0}, {7'd3, 7'd2, 7'd1, 7'd0});
      idle("t4", 3);
      check("t4.max", 32'(max_score), 32'd0);
      check("t4.row", 32'(max_row), 32'd0);
      check("t4.col", 32'(max_col), 32'd0);
      check("t4.done", 32'(done), 32'd1);

      // Abort during DRAIN with 250 in flight
      beat("t5", 1'b1, 1'b1, 1'b0, 4'b1111, {8'd40, 8'd3, 8'd2, 8'd1},
           {7'd1, 7'd1, 7'd1, 7'd1}, {7'd1, 7'd1, 7'd1, 7'd1});
      beat("t5", 1'b0, 1'b1, 1'b1, 4'b1111, {8'd1, 8'd250, 8'd2, 8'd3},
           {7'd2, 7'd2, 7'd2, 7'd2}, {7'd2, 7'd2, 7'd2, 7'd2});
      idle("t5", 1);
      check("t5.no250a", 32'(max_score == 8'd250), 32'd0);
      beat("t5", 1'b1, 1'b1, 1'b1, 4'b1111, {8'd1, 8'd9, 8'd60, 8'd7},
           {7'd4, 7'd4, 7'd6, 7'd4}, {7'd5, 7'd5, 7'd8, 7'd5});
      for (int i = 0; i < 3; i++) begin
         check("t5.no250", 32'(max_score == 8'd250), 32'd0);
         if (i < 2) check("t5.nodone", 32'(done), 32'd0);
         idle("t5", 1);
      end
      check("t5.max", 32'(max_score), 32'd60);
      check("t5.row", 32'(max_row), 32'd6);
      check("t5.done", 32'(done), 32'd1);

      // Reset mid-ACTIVE, reset over start, then in_valid ignored until start
      beat("t6", 1'b1, 1'b1, 1'b0, 4'b1111, {8'd70, 8'd3, 8'd2, 8'd1}, 28'd5, 28'd5);
      beat("t6", 1'b0, 1'b1, 1'b0, 4'b1111, {8'd1, 8'd80, 8'd2, 8'd3}, 28'd5, 28'd5);
      beat("t6", 1'b0, 1'b1, 1'b0, 4'b1111, {8'd1, 8'd2, 8'd2, 8'd3}, 28'd5, 28'd5);
      rst_n = 1'b0;
      beat("t6r", 1'b0, 1'b1, 1'b1, 4'b1111, {8'd1, 8'd2, 8'd2, 8'd3}, 28'd5, 28'd5);
      check("t6.rst_max", 32'(max_score), 32'd0);
      check("t6.rst_busy", 32'(busy), 32'd0);
      beat("t6r", 1'b1, 1'b1, 1'b1, 4'b1111, {8'd1, 8'd2, 8'd2, 8'd3}, 28'd5, 28'd5);
      check("t6.rst_prio", 32'(busy), 32'd0);
      rst_n = 1'b1;
      beat("t6i", 1'b0, 1'b1, 1'b1, 4'b1111, {8'd111, 8'd2, 8'd2, 8'd3}, 28'd5, 28'd5);
      beat("t6i", 1'b0, 1'b1, 1'b0, 4'b1111, {8'd112, 8'd2, 8'd2, 8'd3}, 28'd5, 28'd5);
      idle("t6i", 4);
      check("t6.ign_max", 32'(max_score), 32'd0);
      check("t6.ign_done", 32'(done), 32'd0);
      check("t6.ign_rv", 32'(result_valid), 32'd0);

      // Randomized frames with gaps, garbage in IDLE/DRAIN and early aborts
      for (int f = 0; f < 60; f++) begin
         int nb;
         int gap;
         nb = $urandom_range(1, 5);
         for (int b = 0; b < nb; b++) begin
            if (b > 0 && $urandom_range(0, 3) == 0) idle("rnd_gap", 1);
            rand_lanes();
            start = (b == 0); in_valid = 1'b1; in_last = (b == nb - 1);
            tick("rnd");
         end
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) begin
            rand_lanes();
            start = 1'b0; in_valid = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
            tick("rnd_idle");
         end
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 1'b0;
            idle("rnd_rst", 1);
            rst_n = 1'b1;
         end
      end
      idle("tail", 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
